// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU instruction sequencer: field positions,
// op/ext nibble codes, full 8-bit ALU opcodes, FSM encoding and decode payload.
package alu_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned CNT_W   = 4;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned EXT_MSB = 7;
  localparam int unsigned EXT_LSB = 4;
  localparam int unsigned RS_MSB  = 3;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Primary op nibbles with special meaning
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h8;

  // ALU function nibbles (ext field for register form, op field for immediate form)
  localparam logic [3:0] X_AND  = 4'h1;
  localparam logic [3:0] X_OR   = 4'h2;
  localparam logic [3:0] X_XOR  = 4'h3;
  localparam logic [3:0] X_ADD  = 4'h5;
  localparam logic [3:0] X_ADDU = 4'h6;
  localparam logic [3:0] X_ADDC = 4'h7;
  localparam logic [3:0] X_SUB  = 4'h9;
  localparam logic [3:0] X_SUBC = 4'hA;
  localparam logic [3:0] X_CMP  = 4'hB;
  localparam logic [3:0] X_MOV  = 4'hD;
  localparam logic [3:0] X_MUL  = 4'hE;

  // Shift ext nibbles under OP_SHIFT
  localparam logic [3:0] X_LSH  = 4'h8;
  localparam logic [3:0] X_ASHU = 4'hF;

  // Full register-form ALU opcodes as seen on the opcode bus
  localparam logic [OPC_W-1:0] OPC_AND  = 8'h01;
  localparam logic [OPC_W-1:0] OPC_OR   = 8'h02;
  localparam logic [OPC_W-1:0] OPC_XOR  = 8'h03;
  localparam logic [OPC_W-1:0] OPC_ADD  = 8'h05;
  localparam logic [OPC_W-1:0] OPC_SUB  = 8'h09;
  localparam logic [OPC_W-1:0] OPC_CMP  = 8'h0B;
  localparam logic [OPC_W-1:0] OPC_MOV  = 8'h0D;
  localparam logic [OPC_W-1:0] OPC_MUL  = 8'h0E;
  localparam logic [OPC_W-1:0] OPC_LSH  = 8'h88;
  localparam logic [OPC_W-1:0] OPC_ASHU = 8'h8F;

  // Sequencer state encoding
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  // Decoder result for one instruction word
  typedef struct packed {
    logic legal;
    logic rori;
    logic flag_en;
    logic writes;
    logic is_mul;
  } dec_t;

  // True for the function codes shared by register and immediate forms
  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {X_AND, X_OR, X_XOR, X_ADD, X_ADDU, X_ADDC,
                        X_SUB, X_SUBC, X_CMP, X_MOV, X_MUL};
  endfunction

  // True for the arithmetic codes that update the flag register
  function automatic logic is_flag_code(input logic [3:0] code);
    return code inside {X_ADD, X_ADDU, X_ADDC, X_SUB, X_SUBC, X_CMP, X_MUL};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: legality, operand form, flag/write
// enables and multiply detection for one 16-bit instruction word.
module instr_decode
  import alu_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output dec_t               o_dec_c
);

  logic [3:0] w_op;
  logic [3:0] w_ext;

  assign w_op  = i_instr[OP_MSB:OP_LSB];
  assign w_ext = i_instr[EXT_MSB:EXT_LSB];

  // Classify the word; anything not matched stays illegal (all zero)
  always_comb begin
    o_dec_c = '0;
    if (i_instr == '0) begin
      o_dec_c.legal = 1'b1;
    end else if (w_op == OP_REG) begin
      if (is_alu_code(w_ext)) begin
        o_dec_c.legal   = 1'b1;
        o_dec_c.rori    = 1'b0;
        o_dec_c.flag_en = is_flag_code(w_ext);
        o_dec_c.writes  = (w_ext != X_CMP);
        o_dec_c.is_mul  = (w_ext == X_MUL);
      end
    end else if (w_op == OP_SHIFT) begin
      if (w_ext == X_LSH || w_ext == X_ASHU) begin
        o_dec_c.legal  = 1'b1;
        o_dec_c.rori   = 1'b0;
        o_dec_c.writes = 1'b1;
      end else if (w_ext[3:2] == 2'b00) begin
        o_dec_c.legal  = 1'b1;
        o_dec_c.rori   = 1'b1;
        o_dec_c.writes = 1'b1;
      end
    end else if (is_alu_code(w_op)) begin
      o_dec_c.legal   = 1'b1;
      o_dec_c.rori    = 1'b1;
      o_dec_c.flag_en = is_flag_code(w_op);
      o_dec_c.writes  = (w_op != X_CMP);
      o_dec_c.is_mul  = (w_op == X_MUL);
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch-side sequencer: accepts instruction words on a valid/ready handshake
// and drives registered register-file/ALU controls, stretching MUL over
// MUL_LAT cycles with write-back only in the final cycle.
module alu_instr_sequencer
  import alu_isa_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned NREGS   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [NREGS-1:0]   reg_wen,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   Rsrc,
  output logic [REG_W-1:0]   Rdest,
  output logic [IMM_W-1:0]   imm,
  output logic               RorI,
  output logic               FlagEn,
  output logic               busy,
  output logic               illegal,
  output logic [15:0]        retired
);

  dec_t w_dec;

  instr_decode u_decode (
    .i_instr (instr),
    .o_dec_c (w_dec)
  );

  logic [0:0]       r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic             r_ready,    w_ready_nxt;
  logic             r_busy,     w_busy_nxt;
  logic [NREGS-1:0] r_reg_wen,  w_reg_wen_nxt;
  logic [OPC_W-1:0] r_opcode,   w_opcode_nxt;
  logic [REG_W-1:0] r_rsrc,     w_rsrc_nxt;
  logic [REG_W-1:0] r_rdest,    w_rdest_nxt;
  logic [IMM_W-1:0] r_imm,      w_imm_nxt;
  logic             r_rori,     w_rori_nxt;
  logic             r_flag_en,  w_flag_en_nxt;
  logic             r_illegal,  w_illegal_nxt;
  logic [15:0]      r_retired,  w_retired_nxt;
  logic [NREGS-1:0] r_pend_wen, w_pend_wen_nxt;
  logic             r_pend_flg, w_pend_flg_nxt;
  logic             r_retire,   w_retire_nxt;

  logic             w_done;
  logic             w_accept;
  logic [NREGS-1:0] w_onehot;

  // r_ready mirrors (IDLE or last EXEC cycle), so it doubles as the accept gate
  assign w_done   = (r_state == S_EXEC) && (r_cnt == '0);
  assign w_accept = instr_valid && r_ready;
  assign w_onehot = NREGS'(1) << instr[RD_MSB:RD_LSB];

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_opcode_nxt   = r_opcode;
    w_rsrc_nxt     = r_rsrc;
    w_rdest_nxt    = r_rdest;
    w_imm_nxt      = r_imm;
    w_rori_nxt     = r_rori;
    w_pend_wen_nxt = r_pend_wen;
    w_pend_flg_nxt = r_pend_flg;
    w_retire_nxt   = r_retire;
    w_retired_nxt  = r_retired;
    w_reg_wen_nxt  = '0;
    w_flag_en_nxt  = 1'b0;
    w_illegal_nxt  = 1'b0;

    // Multi-cycle countdown; enables come up only for the final cycle
    if ((r_state == S_EXEC) && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        w_reg_wen_nxt = r_pend_wen;
        w_flag_en_nxt = r_pend_flg;
      end
    end

    // Retire the current instruction and fall back to a cleared IDLE
    if (w_done) begin
      if (r_retire) begin
        w_retired_nxt = r_retired + 16'd1;
      end
      w_state_nxt    = S_IDLE;
      w_opcode_nxt   = '0;
      w_rsrc_nxt     = '0;
      w_rdest_nxt    = '0;
      w_imm_nxt      = '0;
      w_rori_nxt     = 1'b0;
      w_pend_wen_nxt = '0;
      w_pend_flg_nxt = 1'b0;
      w_retire_nxt   = 1'b0;
    end

    // New capture overrides the IDLE fall-back; illegal words load zeroed controls
    if (w_accept) begin
      w_state_nxt    = S_EXEC;
      w_cnt_nxt      = (w_dec.legal && w_dec.is_mul) ? CNT_W'(MUL_LAT - 1) : '0;
      w_opcode_nxt   = w_dec.legal ? {instr[OP_MSB:OP_LSB], instr[EXT_MSB:EXT_LSB]} : '0;
      w_rsrc_nxt     = w_dec.legal ? instr[RS_MSB:RS_LSB] : '0;
      w_rdest_nxt    = w_dec.legal ? instr[RD_MSB:RD_LSB] : '0;
      w_imm_nxt      = w_dec.legal ? instr[IMM_MSB:IMM_LSB] : '0;
      w_rori_nxt     = w_dec.legal && w_dec.rori;
      w_pend_wen_nxt = (w_dec.legal && w_dec.writes) ? w_onehot : '0;
      w_pend_flg_nxt = w_dec.legal && w_dec.flag_en;
      w_retire_nxt   = w_dec.legal;
      w_illegal_nxt  = !w_dec.legal;
      if (w_cnt_nxt == '0) begin
        w_reg_wen_nxt = w_pend_wen_nxt;
        w_flag_en_nxt = w_pend_flg_nxt;
      end
    end

    w_ready_nxt = (w_cnt_nxt == '0);
    w_busy_nxt  = (w_state_nxt == S_EXEC);
  end

  // State and output registers; reset drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_reg_wen  <= '0;
      r_opcode   <= '0;
      r_rsrc     <= '0;
      r_rdest    <= '0;
      r_imm      <= '0;
      r_rori     <= 1'b0;
      r_flag_en  <= 1'b0;
      r_illegal  <= 1'b0;
      r_retired  <= '0;
      r_pend_wen <= '0;
      r_pend_flg <= 1'b0;
      r_retire   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_reg_wen  <= w_reg_wen_nxt;
      r_opcode   <= w_opcode_nxt;
      r_rsrc     <= w_rsrc_nxt;
      r_rdest    <= w_rdest_nxt;
      r_imm      <= w_imm_nxt;
      r_rori     <= w_rori_nxt;
      r_flag_en  <= w_flag_en_nxt;
      r_illegal  <= w_illegal_nxt;
      r_retired  <= w_retired_nxt;
      r_pend_wen <= w_pend_wen_nxt;
      r_pend_flg <= w_pend_flg_nxt;
      r_retire   <= w_retire_nxt;
    end
  end

  assign instr_ready = r_ready;
  assign busy        = r_busy;
  assign reg_wen     = r_reg_wen;
  assign opcode      = r_opcode;
  assign Rsrc        = r_rsrc;
  assign Rdest       = r_rdest;
  assign imm         = r_imm;
  assign RorI        = r_rori;
  assign FlagEn      = r_flag_en;
  assign illegal     = r_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: stimulus pushes one expected
// control snapshot per EXEC cycle; the monitor pops and compares on every busy cycle.
module tb_alu_instr_sequencer;

  localparam int unsigned NREGS   = 16;
  localparam int unsigned MUL_LAT = 3;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] reg_wen;
  logic [7:0]  opcode;
  logic [3:0]  Rsrc;
  logic [3:0]  Rdest;
  logic [7:0]  imm;
  logic        RorI;
  logic        FlagEn;
  logic        busy;
  logic        illegal;
  logic [15:0] retired;

  alu_instr_sequencer #(
    .MUL_LAT (MUL_LAT),
    .NREGS   (NREGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_wen     (reg_wen),
    .opcode      (opcode),
    .Rsrc        (Rsrc),
    .Rdest       (Rdest),
    .imm         (imm),
    .RorI        (RorI),
    .FlagEn      (FlagEn),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired)
  );

  typedef struct packed {
    logic [15:0] wen;
    logic [7:0]  opc;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic        rori;
    logic        fl;
    logic        ill;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_exec  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ex(input logic [15:0] wen, input logic [7:0] opc,
                              input logic [3:0] rs, input logic [3:0] rd,
                              input logic [7:0] im, input logic rori,
                              input logic fl, input logic ill, input logic rdy);
    return {wen, opc, rs, rd, im, rori, fl, ill, rdy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard comparison per EXEC cycle
  always @(negedge clk) begin : monitor
    exp_t act;
    exp_t e;
    if (!rst && busy) begin
      act = {reg_wen, opcode, Rsrc, Rdest, imm, RorI, FlagEn, illegal, instr_ready};
      n_tests++;
      n_exec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL exec%0d: unexpected busy cycle, got wen=%h opc=%h", n_exec, reg_wen, opcode);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL exec%0d: got wen=%h opc=%h rs=%h rd=%h imm=%h rori=%b fl=%b ill=%b rdy=%b expected wen=%h opc=%h rs=%h rd=%h imm=%h rori=%b fl=%b ill=%b rdy=%b",
                   n_exec, act.wen, act.opc, act.rs, act.rd, act.imm, act.rori, act.fl, act.ill, act.rdy,
                   e.wen, e.opc, e.rs, e.rd, e.imm, e.rori, e.fl, e.ill, e.rdy);
        end
      end
    end
  end

  // Present a word and hold it until the edge that captures it
  task automatic issue(input logic [15:0] w);
    int k;
    k = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!instr_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: instr_ready stayed 0 for word %h", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_controls", 32'({reg_wen, opcode, Rsrc, Rdest, imm, RorI, FlagEn, illegal, busy}), 32'h0);
    check("rst_imm_opc", 32'({imm, opcode}), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    check("rst_retired", 32'(retired), 32'h0);

    // Back-to-back ADD R2,R1 then MOVI R2,#20
    q.push_back(ex(16'h0004, 8'h05, 4'h1, 4'h2, 8'h51, 1'b0, 1'b1, 1'b0, 1'b1));
    q.push_back(ex(16'h0004, 8'hD1, 4'h4, 4'h2, 8'h14, 1'b1, 1'b0, 1'b0, 1'b1));
    issue(16'h0251);
    issue(16'hD214);
    idle(3);
    check("retired_after_add_movi", 32'(retired), 32'd2);
    check("drain1", 32'(q.size()), 32'd0);

    // MUL R1,R2 stretched over 3 cycles, write-back only in the last
    q.push_back(ex(16'h0000, 8'h0E, 4'h2, 4'h1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(ex(16'h0000, 8'h0E, 4'h2, 4'h1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(ex(16'h0002, 8'h0E, 4'h2, 4'h1, 8'hE2, 1'b0, 1'b1, 1'b0, 1'b1));
    issue(16'h01E2);
    idle(5);
    check("retired_after_mul", 32'(retired), 32'd3);
    check("drain2", 32'(q.size()), 32'd0);

    // CMP (no write) followed by an undecodable word
    q.push_back(ex(16'h0000, 8'h0B, 4'h4, 4'h3, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b1));
    q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    issue(16'h03B4);
    issue(16'h0F41);
    idle(3);
    check("retired_after_cmp_ill", 32'(retired), 32'd4);

    // Immediate, shift, illegal variants, NOP, MULI then ADD right behind it
    q.push_back(ex(16'h0008, 8'h50, 4'h5, 4'h3, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1)); // ADDI
    q.push_back(ex(16'h0400, 8'h88, 4'h1, 4'hA, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1)); // LSH
    q.push_back(ex(16'h8000, 8'h81, 4'h3, 4'hF, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1)); // LSHI
    q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1)); // bad shift ext
    q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1)); // bad op 4
    q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)); // NOP
    q.push_back(ex(16'h0000, 8'hE0, 4'hA, 4'h1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0)); // MULI
    q.push_back(ex(16'h0000, 8'hE0, 4'hA, 4'h1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0));
    q.push_back(ex(16'h0002, 8'hE0, 4'hA, 4'h1, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b1));
    q.push_back(ex(16'h0004, 8'h05, 4'h1, 4'h2, 8'h51, 1'b0, 1'b1, 1'b0, 1'b1)); // ADD
    issue(16'h5305);
    issue(16'h8A81);
    issue(16'h8F13);
    issue(16'h8F51);
    issue(16'h4123);
    issue(16'h0000);
    issue(16'hE10A);
    issue(16'h0251);
    idle(3);
    check("retired_after_mix", 32'(retired), 32'd10);
    check("drain3", 32'(q.size()), 32'd0);

    // Reset during MUL cycle 2: no write-back, IDLE afterwards
    q.push_back(ex(16'h0000, 8'h0E, 4'h2, 4'h1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(16'h01E2);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mul_cycle2_no_wen", 32'(reg_wen), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_mul_busy", 32'(busy), 32'h0);
    check("rst_mid_mul_wen", 32'(reg_wen), 32'h0);
    check("rst_mid_mul_ready", 32'(instr_ready), 32'h1);
    check("rst_mid_mul_retired", 32'(retired), 32'h0);
    idle(4);
    check("post_rst_wen", 32'({reg_wen, FlagEn, busy}), 32'h0);
    check("drain4", 32'(q.size()), 32'd0);

    // Retired counter wrap: 65535 NOPs then one more
    for (int i = 0; i < 65535; i++) begin
      q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
      issue(16'h0000);
    end
    idle(2);
    check("retired_ffff", 32'(retired), 32'h0000FFFF);
    q.push_back(ex(16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(16'h0000);
    idle(2);
    check("retired_wrap", 32'(retired), 32'h0);
    check("drain5", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
